edge_event_monitor: RTL and testbench
=====================================

EDGE_EVENT_MONITOR -- requirements
Module: edge_event_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of counters, run length and timestamp.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, event FIFO entries; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port a_i, input, 1, monitored signal.
REQ-006 SHALL have port clr_i, input, 1, synchronous clear of counters and ovf_o.
REQ-007 SHALL have ports rose_o, fell_o, changed_o, stable_o, output, 1 each, per-sample edge flags.
REQ-008 SHALL have ports rose_cnt_o and fell_cnt_o, output, CNT_W each, saturating edge counts.
REQ-009 SHALL have port run_len_o, output, CNT_W, count of consecutive stable samples.
REQ-010 SHALL have ports evt_valid_o (output, 1), evt_ready_i (input, 1), evt_type_o (output, 1, 1=rise, 0=fall) and evt_time_o (output, CNT_W), forming the event stream.
REQ-011 SHALL have port ovf_o, output, 1, sticky flag set when an event is dropped.

Function
REQ-012 SHALL sample a_i into a_q on every rising clk edge and copy the prior a_q into a_qq.
REQ-013 SHALL drive rose_o = a_q & ~a_qq, fell_o = ~a_q & a_qq, changed_o = a_q ^ a_qq and stable_o = ~changed_o, all from flops with no combinational path from a_i.
REQ-014 SHALL raise the flags in the cycle after the sampling edge (latency 1) and hold each pulse exactly one cycle per sampled transition.
REQ-015 SHALL ignore a_i activity between clock edges; only sampled values count.
REQ-016 SHALL increment rose_cnt_o or fell_cnt_o by 1 in each cycle its flag is high, saturating at 2^CNT_W-1 with no wrap.
REQ-017 SHALL set run_len_o to 0 in each cycle changed_o is high, otherwise add 1, saturating at 2^CNT_W-1.
REQ-018 SHALL keep a free-running CNT_W timestamp that increments every cycle, wraps to 0, and is unaffected by clr_i.
REQ-019 SHALL push {type, timestamp-of-that-cycle} into the FIFO in every cycle changed_o is high.
REQ-020 SHALL pop on evt_valid_o & evt_ready_i; evt_valid_o is high iff the FIFO is non-empty, with oldest-first order.
REQ-021 SHALL hold evt_type_o and evt_time_o stable while evt_valid_o is high and evt_ready_i is low.
REQ-022 SHALL, on a push to a full FIFO without a simultaneous pop, drop the new event, keep the stored ones and set ovf_o.
REQ-023 SHALL accept the push when full with a simultaneous pop, leaving the occupancy unchanged and ovf_o unset.
REQ-024 SHALL, on clr_i, zero rose_cnt_o, fell_cnt_o and ovf_o the next cycle, giving clr_i priority over a same-cycle increment or set.
REQ-025 SHALL NOT flush the FIFO on clr_i; an edge in the clr_i cycle is still pushed.

Reset
REQ-026 SHALL, on rst_n low, immediately clear a_q, a_qq, all counters, the timestamp, FIFO pointers and ovf_o; all outputs 0 except stable_o=1.
REQ-027 SHALL discard queued events when reset is asserted mid-operation; evt_valid_o goes 0 without waiting for clk.
REQ-028 SHALL, after reset release, treat the first sampled 1 as a rise, since a_qq resets to 0.

Configuration
REQ-029 SHALL, with EDGE_MON_SYNC_EN defined, insert a two-flop synchronizer on a_i before a_q, giving latency 3 cycles from a_i to the flags; the synchronizer flops reset to 0.
REQ-030 SHALL, without EDGE_MON_SYNC_EN, register a_i directly into a_q with latency 1; all other behaviour is identical.

Verification
REQ-031 SHALL check: reset then a_i=0 held 5 cycles -> stable_o=1, run_len_o 1,2,3,4,5, evt_valid_o=0, counters 0.
REQ-032 SHALL check: a_i 0->1 before edge k, held -> rose_o=changed_o=1 in cycle k+1 only, rose_cnt_o=1, one event of type 1 with time equal to the timestamp in cycle k+1.
REQ-033 SHALL check: a 2 ns high glitch on a_i between edges (10 ns period) -> no flags, no events, run_len_o keeps counting.
REQ-034 SHALL check: evt_ready_i=0 and a_i toggled every cycle for 6 edges -> 4 events queued, ovf_o=1; draining yields types 1,0,1,0 with consecutive timestamps.
REQ-035 SHALL check: CNT_W=4 with 20 rising edges -> rose_cnt_o=15, then clr_i pulse -> 0 and ovf_o=0.
REQ-036 SHALL check: rst_n low with 2 events queued -> evt_valid_o=0 and all counters 0 before the next clk edge.

Source files
------------

// File: rtl/edge_event_monitor.sv
// rtl/edge_event_monitor.sv - sampled edge detector with saturating counters, run length and timestamped event FIFO
// Optional input synchronizer enabled by defining EDGE_MON_SYNC_EN.

module edge_event_monitor #(
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_i,
    input  logic             clr_i,
    output logic             rose_o,
    output logic             fell_o,
    output logic             changed_o,
    output logic             stable_o,
    output logic [CNT_W-1:0] rose_cnt_o,
    output logic [CNT_W-1:0] fell_cnt_o,
    output logic [CNT_W-1:0] run_len_o,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic             evt_type_o,
    output logic [CNT_W-1:0] evt_time_o,
    output logic             ovf_o
);

    localparam int              AW      = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [AW:0]      PTR_ONE = (AW + 1)'(1);

    logic             a_in;
    logic             a_q;
    logic             a_qq;
    logic [CNT_W-1:0] rose_cnt_q;
    logic [CNT_W-1:0] fell_cnt_q;
    logic [CNT_W-1:0] run_len_q;
    logic [CNT_W-1:0] ts_q;
    logic             ovf_q;

    logic [CNT_W:0]   mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push_ok;
    logic             drop;
    logic [CNT_W:0]   head;

`ifdef EDGE_MON_SYNC_EN
    logic sync_q1;
    logic sync_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= a_i;
            sync_q2 <= sync_q1;
        end
    end

    assign a_in = sync_q2;
`else
    assign a_in = a_i;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= 1'b0;
            a_qq <= 1'b0;
        end else begin
            a_q  <= a_in;
            a_qq <= a_q;
        end
    end

    // Flags decode only registered samples, so a_i never reaches an output combinationally.
    assign rose_o    = a_q & ~a_qq;
    assign fell_o    = ~a_q & a_qq;
    assign changed_o = a_q ^ a_qq;
    assign stable_o  = ~changed_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rose_cnt_q <= '0;
            fell_cnt_q <= '0;
            run_len_q  <= '0;
            ts_q       <= '0;
        end else begin
            ts_q <= ts_q + CNT_ONE;

            if (clr_i) begin
                rose_cnt_q <= '0;
            end else if (rose_o && (rose_cnt_q != CNT_MAX)) begin
                rose_cnt_q <= rose_cnt_q + CNT_ONE;
            end

            if (clr_i) begin
                fell_cnt_q <= '0;
            end else if (fell_o && (fell_cnt_q != CNT_MAX)) begin
                fell_cnt_q <= fell_cnt_q + CNT_ONE;
            end

            if (changed_o) begin
                run_len_q <= '0;
            end else if (run_len_q != CNT_MAX) begin
                run_len_q <= run_len_q + CNT_ONE;
            end
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = evt_valid_o & evt_ready_i;
    // A pop frees the slot being written this cycle, so a full FIFO can still take the push.
    assign push_ok    = changed_o & (~fifo_full | pop);
    assign drop       = changed_o & fifo_full & ~pop;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= {a_q, ts_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (clr_i) begin
                ovf_q <= 1'b0;
            end else if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign head        = mem[rd_ptr[AW-1:0]];
    assign evt_valid_o = ~fifo_empty;
    assign evt_type_o  = evt_valid_o & head[CNT_W];
    assign evt_time_o  = evt_valid_o ? head[CNT_W-1:0] : '0;

    assign rose_cnt_o = rose_cnt_q;
    assign fell_cnt_o = fell_cnt_q;
    assign run_len_o  = run_len_q;
    assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_edge_event_monitor.sv
// tb/tb_edge_event_monitor.sv - directed and random checks of edge_event_monitor against a behavioural model

module tb_edge_event_monitor;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_i;
    logic       clr_i;
    logic       evt_ready_i;

    logic       rose_o, fell_o, changed_o, stable_o, evt_valid_o, evt_type_o, ovf_o;
    logic [7:0] rose_cnt_o, fell_cnt_o, run_len_o, evt_time_o;

    logic       r4_rose, r4_fell, r4_chg, r4_stable, r4_valid, r4_type, r4_ovf;
    logic [3:0] r4_rose_cnt, r4_fell_cnt, r4_run, r4_time;

    edge_event_monitor #(.CNT_W(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .a_i(a_i), .clr_i(clr_i),
        .rose_o(rose_o), .fell_o(fell_o), .changed_o(changed_o), .stable_o(stable_o),
        .rose_cnt_o(rose_cnt_o), .fell_cnt_o(fell_cnt_o), .run_len_o(run_len_o),
        .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i), .evt_type_o(evt_type_o),
        .evt_time_o(evt_time_o), .ovf_o(ovf_o)
    );

    edge_event_monitor #(.CNT_W(4), .FIFO_DEPTH(DEPTH)) dut4 (
        .clk(clk), .rst_n(rst_n), .a_i(a_i), .clr_i(clr_i),
        .rose_o(r4_rose), .fell_o(r4_fell), .changed_o(r4_chg), .stable_o(r4_stable),
        .rose_cnt_o(r4_rose_cnt), .fell_cnt_o(r4_fell_cnt), .run_len_o(r4_run),
        .evt_valid_o(r4_valid), .evt_ready_i(evt_ready_i), .evt_type_o(r4_type),
        .evt_time_o(r4_time), .ovf_o(r4_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit typ;
        int tm;
    } evt_t;

    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   m_q, m_qq, m_s1, m_s2, m_ovf;
    int   m_rose, m_fell, m_run, m_ts;
    evt_t m_fifo[$];

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_q = 0; m_qq = 0; m_s1 = 0; m_s2 = 0; m_ovf = 0;
        m_rose = 0; m_fell = 0; m_run = 0; m_ts = 0;
        m_fifo.delete();
    endfunction

    // One rising edge of behaviour, computed from the values visible before the edge.
    function automatic void model_step();
        bit rose, fell, chg, pop, in_bit;
        int sz;
        rose = m_q && !m_qq;
        fell = !m_q && m_qq;
        chg  = m_q != m_qq;
        sz   = m_fifo.size();
        pop  = (sz > 0) && evt_ready_i;
        if (pop) void'(m_fifo.pop_front());
        if (chg) begin
            if (sz < DEPTH || pop) m_fifo.push_back('{m_q, m_ts});
            else m_ovf = 1;
        end
        if (clr_i) begin
            m_rose = 0; m_fell = 0; m_ovf = 0;
        end else begin
            m_rose += int'(rose);
            m_fell += int'(fell);
        end
        m_run = chg ? 0 : ((m_run < 100000) ? m_run + 1 : m_run);
        m_ts++;
`ifdef EDGE_MON_SYNC_EN
        in_bit = m_s2;
        m_s2   = m_s1;
        m_s1   = a_i;
`else
        in_bit = a_i;
`endif
        m_qq = m_q;
        m_q  = in_bit;
    endfunction

    task automatic check_all();
        chk("rose", rose_o, m_q && !m_qq);
        chk("fell", fell_o, !m_q && m_qq);
        chk("changed", changed_o, m_q != m_qq);
        chk("stable", stable_o, m_q == m_qq);
        chk("rose_cnt", rose_cnt_o, sat(m_rose, 8));
        chk("fell_cnt", fell_cnt_o, sat(m_fell, 8));
        chk("run_len", run_len_o, sat(m_run, 8));
        chk("ovf", ovf_o, m_ovf);
        chk("evt_valid", evt_valid_o, m_fifo.size() > 0);
        if (m_fifo.size() > 0) begin
            chk("evt_type", evt_type_o, m_fifo[0].typ);
            chk("evt_time", evt_time_o, m_fifo[0].tm & 255);
        end
        chk("w4_rose_cnt", r4_rose_cnt, sat(m_rose, 4));
        chk("w4_fell_cnt", r4_fell_cnt, sat(m_fell, 4));
        chk("w4_run_len", r4_run, sat(m_run, 4));
    endtask

    task automatic cycle();
        if (rst_n) model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        int t0;
        rst_n = 1'b0; a_i = 1'b0; clr_i = 1'b0; evt_ready_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset_stable", stable_o, 1);
        rst_n = 1'b1;

        for (int k = 1; k <= 5; k++) begin
            cycle();
            chk("idle_run_len", run_len_o, k);
        end

        a_i = 1'b1;
        cycle();
        chk("rise_flag", rose_o, 1);
        cycle();
        chk("rise_once", rose_o, 0);
        chk("rise_cnt_one", rose_cnt_o, 1);
        chk("rise_evt_type", evt_type_o, 1);

        a_i = 1'b0;
        repeat (2) cycle();
        evt_ready_i = 1'b1;
        repeat (3) cycle();
        for (int g = 0; g < 3; g++) begin
            #2 a_i = 1'b1;
            #2 a_i = 1'b0;
            cycle();
            chk("glitch_nochange", changed_o, 0);
            chk("glitch_noevt", evt_valid_o, 0);
        end

        evt_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a_i = ~a_i;
            cycle();
        end
        cycle();
        chk("full_ovf", ovf_o, 1);
        chk("full_count", m_fifo.size(), DEPTH);
        t0 = int'(evt_time_o);
        evt_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_type", evt_type_o, (i % 2) == 0);
            chk("drain_time", evt_time_o, (t0 + i) & 255);
            cycle();
        end
        chk("drained", evt_valid_o, 0);

        for (int i = 0; i < 40; i++) begin
            a_i = ~a_i;
            cycle();
        end
        cycle();
        chk("sat4_rose", r4_rose_cnt, 15);
        clr_i = 1'b1;
        cycle();
        clr_i = 1'b0;
        chk("clr_rose4", r4_rose_cnt, 0);
        chk("clr_rose8", rose_cnt_o, 0);
        chk("clr_ovf", ovf_o, 0);

        a_i = 1'b1;
        repeat (300) cycle();
        chk("run_sat", run_len_o, 255);

        for (int i = 0; i < 400; i++) begin
            a_i         = 1'($urandom_range(0, 1));
            evt_ready_i = ($urandom_range(0, 3) != 0);
            clr_i       = ($urandom_range(0, 31) == 0);
            cycle();
        end
        clr_i = 1'b0;

        a_i = 1'b0;
        evt_ready_i = 1'b1;
        repeat (8) cycle();
        evt_ready_i = 1'b0;
        a_i = 1'b1;
        cycle();
        a_i = 1'b0;
        repeat (3) cycle();
        chk("two_queued", m_fifo.size(), 2);
        chk("two_valid", evt_valid_o, 1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("async_valid", evt_valid_o, 0);
        chk("async_rose_cnt", rose_cnt_o, 0);
        chk("async_fell_cnt", fell_cnt_o, 0);
        repeat (2) cycle();
        rst_n = 1'b1;
        a_i = 1'b1;
        cycle();
        chk("post_reset_rise", rose_o, 1);
        repeat (3) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
